tx_frame_feed: RTL
==================

# tx_frame_feed

Upstream feeder for the 10G transmit path. It pops frames from a split data/length packet FIFO, prepends the XGMII start/preamble/SFD octets and realigns the 256-bit words. It optionally pads runt frames, then presents each frame to the XGMII transmit stage using that stage's rts/rdata/rbytes protocol. In that protocol each 256-bit word is held for 4 clk156 cycles and is consumed as four 64-bit lanes, low lane first.

## Interface
- MAX_LEN, 1514: largest accepted frame length in bytes, FCS excluded.
- IPG_CYC, 4: idle clk156 cycles inserted after a frame's last word window.
- clk156  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- len_empty  in  1  length FIFO empty.
- len_rd  out  1  length FIFO pop. Read latency is 1 cycle.
- len_dout  in  16  frame length L in bytes, FCS excluded.
- dat_empty  in  1  data FIFO empty.
- dat_rd  out  1  data FIFO pop. Read latency is 1 cycle.
- dat_dout  in  256  frame bytes, byte 0 at [7:0].
- rts  out  1  one-cycle start-of-frame pulse to the XGMII stage.
- rdata  out  256  output word. Byte 0 at [7:0], lane 0 = [63:0].
- rbytes  out  16  L' + 8, where L' is the padded length.
- frame_cnt  out  32  frames sent. Wraps.
- drop_cnt  out  16  frames dropped. Saturates at 16'hFFFF.
- underrun  out  1  sticky protocol-error flag.

## Operation
- Producer rule: all ceil(L/32) data words of a frame are written before the frame's length entry.
- FSM states: IDLE → LEN_RD → LEN_CHK → FETCH → HOLD → GAP → IDLE. Drop path: LEN_CHK → DROP → IDLE.
- **IDLE:** move to LEN_RD when len_empty=0.
- **LEN_RD:** pop the length FIFO.
- **LEN_CHK:**
  - Latch L.
  - If L=0 or L>MAX_LEN, go to DROP.
  - Otherwise compute the following, all as 16-bit values:
    - L' = max(L, 60) when padding is enabled, else L.
    - W = ceil((L'+8)/32), the number of output words.
    - Wi = ceil(L/32), the number of input words.
- **Realign:**
  - out[k] = {in[k][191:0], carry}.
  - carry is 64'hD5555555555555FB for k=0, otherwise in[k-1][255:192].
  - When k ≥ Wi, in[k] is treated as zero. This produces the extra tail word when W > Wi.
  - Bytes at positions ≥ L+8 within out[] are forced to zero.
- **FETCH:** pop data word 0 and form out[0].
- **HOLD:**
  - Per word, a 2-bit phase counter runs 0..3.
  - At phase 0, pop the next input word if k+1 < Wi.
  - The next out word is loaded at the phase-3 to phase-0 boundary.
  - After word W-1 phase 3, go to GAP.
- **GAP:** wait IPG_CYC cycles, then go to IDLE.
- **DROP:**
  - Pop and discard Wi data words, one per cycle.
  - Increment drop_cnt.
  - No rts is issued.
- **Underrun:** if dat_empty=1 when a pop is required in FETCH or HOLD:
  - Set underrun.
  - Skip the pop and substitute a zero word.
  - Frame timing is unchanged.
- frame_cnt increments on every rts.
- rbytes is held from rts until the next rts.

## Timing
- **Reset values:** rts=0, rdata=0, rbytes=0, len_rd=0, dat_rd=0, frame_cnt=0, drop_cnt=0, underrun=0, FSM=IDLE.
- **Reset mid-frame:**
  - Outputs return to their reset values on the next edge.
  - Partial-frame FIFO contents are not drained; the producer resets too.
- **Start latency:** with len_dout valid at cycle c+1 from a pop at c, rts=1 at cycle t=c+3. rdata = out[0] and rbytes are valid in that same cycle.
- **Word windows:**
  - out[0] is held cycles t..t+4.
  - out[k] for k ≥ 1 is held cycles t+1+4k..t+4+4k.
  - rdata changes only on those boundaries.
- **Next rts:** no earlier than cycle t+4W+IPG_CYC+4. This covers the window end, the GAP and the 3-cycle fetch.
- **Pops:** len_rd and dat_rd are never asserted while the corresponding empty flag is 1.
- **Dropped frames:**
  - 2 cycles for LEN_RD and LEN_CHK.
  - Plus Wi DROP cycles, plus 1.
- **Simultaneous events:** frame_cnt and drop_cnt never update in the same cycle.

## Configuration
- **TX_FEED_PAD_EN defined:** frames with L < 60 are zero-padded to 60 bytes, so rbytes = 68.
- **TX_FEED_PAD_EN undefined:**
  - L' = L and rbytes = L + 8.
  - Runts pass through unpadded.

## Structure
- Package tx_feed_pkg holds:
  - PREAMBLE_SFD = 64'hD5555555555555FB.
  - MIN_FRAME = 60.
  - The FSM state enum.
  - The byte-mask function.
- One sub-module, tx_feed_realign (combinational): inputs in word, carry, valid-byte count; output aligned, masked out word.
- The FSM, counters and registers live in tx_frame_feed.

## Test plan
- **L=56:**
  - rts once; rbytes=64; W=2.
  - out[0][63:0]=PREAMBLE_SFD.
  - out[1][63:0] = input word 0 bytes 24..31.
  - Windows are 5 and 4 cycles.
- **L=40, pad enabled:**
  - rbytes=68, W=3, 2 pops.
  - Bytes 40..59 of the frame are zero.
  - out[2] carries only the tail.
- **L=40, pad disabled:** rbytes=48, W=2, out[1] bytes ≥ 48 zero.
- **Two queued frames, L=64 each, IPG_CYC=4:** second rts exactly 4·3+4+4=20 cycles after the first; frame_cnt=2.
- **Length entries 0 then 1600, then L=100:**
  - drop_cnt=2; 50 data words discarded; no rts for the dropped frames.
  - The L=100 frame is sent with rbytes=108.
- **Length present but data FIFO empty at word 1:** underrun=1, out[1] zero-filled, rts spacing unchanged; assert rst mid-HOLD → all outputs zero on the next cycle.

Source files
------------

// File: rtl/tx_feed_pkg.sv
// Shared constants, FSM state encoding and byte-mask helper for the 10G transmit feeder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tx_feed_pkg;

    localparam logic [63:0] PREAMBLE_SFD = 64'hD5555555555555FB;
    localparam logic [15:0] MIN_FRAME    = 16'd60;

    typedef enum logic [2:0] {
        IDLE,
        LEN_RD,
        LEN_CHK,
        FETCH,
        HOLD,
        GAP,
        DROP
    } feed_state_t;

    // Bit j is set when byte j of a 32-byte word lies below the valid-byte count.
    function automatic logic [31:0] byte_mask(input logic [15:0] vb);
        logic [31:0] m;
        for (int j = 0; j < 32; j++) begin
            m[j] = (16'(j) < vb);
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_feed_realign.sv
// Builds one output word: low 24 input bytes shifted up behind an 8-byte carry, tail bytes masked.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module tx_feed_realign
    import tx_feed_pkg::*;
(
    input  logic [255:0] in_word,
    input  logic [63:0]  carry,
    input  logic [15:0]  vb,
    output logic [255:0] out_word
);

    logic [255:0] raw;
    logic [31:0]  mask;

    // Shift by one lane and zero every byte at or beyond the valid count.
    always_comb begin
        raw      = {in_word[191:0], carry};
        mask     = byte_mask(vb);
        out_word = '0;
        for (int j = 0; j < 32; j++) begin
            out_word[8*j +: 8] = mask[j] ? raw[8*j +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/tx_frame_feed.sv
// Pops frames from split length/data FIFOs, prepends preamble/SFD, realigns and feeds the XGMII stage; runt padding under TX_FEED_PAD_EN.
// Latency: rts three cycles after the length pop; each output word held four cycles (first word five).
// Backpressure: none downstream; pops only when the FIFO is non-empty, a starved data pop sets underrun and inserts zeros.
module tx_frame_feed
    import tx_feed_pkg::*;
#(
    parameter int MAX_LEN = 1514,
    parameter int IPG_CYC = 4
) (
    input  logic         clk156,
    input  logic         rst,
    input  logic         len_empty,
    output logic         len_rd,
    input  logic [15:0]  len_dout,
    input  logic         dat_empty,
    output logic         dat_rd,
    input  logic [255:0] dat_dout,
    output logic         rts,
    output logic [255:0] rdata,
    output logic [15:0]  rbytes,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  drop_cnt,
    output logic         underrun
);

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    // The IDLE cycle before the next length pop completes the gap, so GAP itself runs one short.
    localparam logic [7:0]  GAP_LOAD  = (IPG_CYC > 1) ? 8'(IPG_CYC - 1) : 8'd1;

    feed_state_t  state_q, state_d;
    logic [15:0]  len_q, len_d;          // L
    logic [15:0]  lp_q, lp_d;            // L' (padded length)
    logic [15:0]  w_q, w_d;              // output words
    logic [15:0]  wi_q, wi_d;            // input words
    logic [15:0]  k_q, k_d;              // index of the word currently on rdata
    logic [1:0]   phase_q, phase_d;
    logic         lead_q, lead_d;        // extra leading cycle of word 0
    logic [255:0] in_q, in_d;            // next input word waiting for its load
    logic [63:0]  carry_q, carry_d;      // top lane of the previous input word
    logic [15:0]  rem_q, rem_d;          // valid bytes left for the next output word
    logic         pend_q, pend_d;        // a data pop was issued last cycle
    logic [7:0]   gap_q, gap_d;
    logic [15:0]  drop_left_q, drop_left_d;
    logic         rts_q, rts_d;
    logic [255:0] rdata_q, rdata_d;
    logic [15:0]  rbytes_q, rbytes_d;
    logic [31:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;
    logic         underrun_q, underrun_d;

    logic         len_bad;
    logic [15:0]  lp_in, w_in, wi_in;
    logic [16:0]  lp_ext, wi_ext;
    logic         pop0, pop_hold, pop_drop;
    logic [255:0] word0;
    logic [255:0] ra_in, ra_out;
    logic [63:0]  ra_carry;
    logic [15:0]  ra_vb;

    function automatic logic [15:0] rem_next(input logic [15:0] r);
        return (r > 16'd32) ? (r - 16'd32) : 16'd0;
    endfunction

    // Decode the length presented in LEN_CHK into padded length and word counts.
    always_comb begin
        len_bad = (len_dout == 16'd0) || (len_dout > MAX_LEN_W);
`ifdef TX_FEED_PAD_EN
        lp_in   = (len_dout < MIN_FRAME) ? MIN_FRAME : len_dout;
`else
        lp_in   = len_dout;
`endif
        lp_ext  = {1'b0, lp_in} + 17'd39;
        wi_ext  = {1'b0, len_dout} + 17'd31;
        w_in    = {4'b0, lp_ext[16:5]};
        wi_in   = {4'b0, wi_ext[16:5]};
    end

    // Word 0 is popped in LEN_CHK so that out[0] is ready together with rts.
    assign pop0     = (state_q == LEN_CHK) && !len_bad;
    assign pop_hold = (state_q == HOLD) && !lead_q && (phase_q == 2'd0) && ((k_q + 16'd1) < wi_q);
    assign pop_drop = (state_q == DROP) && (drop_left_q != 16'd0);
    assign dat_rd   = (pop0 || pop_hold || pop_drop) && !dat_empty;
    assign len_rd   = (state_q == LEN_RD) && !len_empty;
    assign word0    = pend_q ? dat_dout : '0;

    // Realigner input: preamble carry for the first word, stored input and carry afterwards.
    always_comb begin
        ra_in    = in_q;
        ra_carry = carry_q;
        ra_vb    = rem_q;
        if (state_q == FETCH) begin
            ra_in    = word0;
            ra_carry = PREAMBLE_SFD;
            ra_vb    = len_q + 16'd8;
        end
    end

    tx_feed_realign u_realign (
        .in_word  (ra_in),
        .carry    (ra_carry),
        .vb       (ra_vb),
        .out_word (ra_out)
    );

    // Next-state and next-output logic for the feeder FSM, counters and word pipeline.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        lp_d        = lp_q;
        w_d         = w_q;
        wi_d        = wi_q;
        k_d         = k_q;
        phase_d     = phase_q;
        lead_d      = lead_q;
        in_d        = in_q;
        carry_d     = carry_q;
        rem_d       = rem_q;
        pend_d      = 1'b0;
        gap_d       = gap_q;
        drop_left_d = drop_left_q;
        rts_d       = 1'b0;
        rdata_d     = rdata_q;
        rbytes_d    = rbytes_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        underrun_d  = underrun_q | ((pop0 || pop_hold) && dat_empty);

        case (state_q)
            IDLE: begin
                if (!len_empty) state_d = LEN_RD;
            end
            LEN_RD: begin
                state_d = len_empty ? IDLE : LEN_CHK;
            end
            LEN_CHK: begin
                len_d = len_dout;
                if (len_bad) begin
                    drop_left_d = wi_in;
                    drop_cnt_d  = (drop_cnt_q != 16'hFFFF) ? (drop_cnt_q + 16'd1) : drop_cnt_q;
                    state_d     = DROP;
                end else begin
                    lp_d    = lp_in;
                    w_d     = w_in;
                    wi_d    = wi_in;
                    pend_d  = !dat_empty;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rdata_d     = ra_out;
                rts_d       = 1'b1;
                rbytes_d    = lp_q + 16'd8;
                frame_cnt_d = frame_cnt_q + 32'd1;
                carry_d     = word0[255:192];
                rem_d       = rem_next(len_q + 16'd8);
                in_d        = '0;
                k_d         = 16'd0;
                phase_d     = 2'd0;
                lead_d      = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (lead_q) begin
                    lead_d = 1'b0;
                end else begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            // Missing or beyond-Wi words stay zero.
                            in_d   = '0;
                            pend_d = pop_hold && !dat_empty;
                        end
                        2'd1: begin
                            if (pend_q) in_d = dat_dout;
                        end
                        2'd3: begin
                            if (k_q == (w_q - 16'd1)) begin
                                gap_d   = GAP_LOAD;
                                state_d = (IPG_CYC > 1) ? GAP : IDLE;
                            end else begin
                                k_d     = k_q + 16'd1;
                                rdata_d = ra_out;
                                carry_d = in_q[255:192];
                                rem_d   = rem_next(rem_q);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            GAP: begin
                if (gap_q <= 8'd1) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            DROP: begin
                if (drop_left_q == 16'd0)  state_d     = IDLE;
                else if (!dat_empty)       drop_left_d = drop_left_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk156) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            lp_q        <= '0;
            w_q         <= '0;
            wi_q        <= '0;
            k_q         <= '0;
            phase_q     <= '0;
            lead_q      <= 1'b0;
            in_q        <= '0;
            carry_q     <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            gap_q       <= '0;
            drop_left_q <= '0;
            rts_q       <= 1'b0;
            rdata_q     <= '0;
            rbytes_q    <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            lp_q        <= lp_d;
            w_q         <= w_d;
            wi_q        <= wi_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
            lead_q      <= lead_d;
            in_q        <= in_d;
            carry_q     <= carry_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            drop_left_q <= drop_left_d;
            rts_q       <= rts_d;
            rdata_q     <= rdata_d;
            rbytes_q    <= rbytes_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign rts       = rts_q;
    assign rdata     = rdata_q;
    assign rbytes    = rbytes_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign underrun  = underrun_q;

endmodule
